// File: rtl/stream_mux_pkg.sv
// Shared types and default sizing for the round-robin / forced-select stream mux.
package stream_mux_pkg;

   typedef enum logic {
      MODE_RR    = 1'b0,
      MODE_FIXED = 1'b1
   } mode_e;

   localparam int DEF_N_CH = 4;
   localparam int DEF_W    = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: grants the first requester at or above ptr, wrapping; combinational.
// No state; en low suppresses every grant so the caller can gate on output backpressure.
module rr_arbiter #(
   parameter  int N_CH = 4,
   localparam int IW   = $clog2(N_CH)
) (
   input  logic [N_CH-1:0] req,
   input  logic [IW-1:0]   ptr,
   input  logic            en,
   output logic [N_CH-1:0] gnt,
   output logic [IW-1:0]   gnt_idx
);

   logic [N_CH-1:0] rot;
   logic            found;
   int              sum;

   // Rotate so bit k of rot is the request of channel (ptr + k) mod N_CH.
   assign rot = (req >> ptr) | (req << (N_CH - int'(ptr)));

   always_comb begin
      gnt_idx = '0;
      found   = 1'b0;
      sum     = 0;
      for (int k = 0; k < N_CH; k++) begin
         if (en && !found && rot[k]) begin
            found = 1'b1;
            sum   = int'(ptr) + k;
            if (sum >= N_CH) begin
               sum = sum - N_CH;
            end
            gnt_idx = IW'(sum);
         end
      end
   end

   assign gnt = found ? (N_CH'(1) << gnt_idx) : '0;

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel to 1 stream mux, round-robin or forced select; 1-cycle latency, registered output.
// in_ready only toward the granted channel and only when the output register can load.
module stream_mux_rr
   import stream_mux_pkg::*;
#(
   parameter  int N_CH = DEF_N_CH,
   parameter  int W    = DEF_W,
   localparam int IW   = $clog2(N_CH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_CH-1:0]          in_valid,
   output logic [N_CH-1:0]          in_ready,
   input  logic [N_CH-1:0][W-1:0]   in_data,
   input  logic                     mode,
   input  logic [IW-1:0]            sel,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [W-1:0]             out_data,
   output logic [IW-1:0]            out_ch
);

   typedef struct packed {
      logic [IW-1:0] ch;
      logic [W-1:0]  dat;
   } out_t;

   out_t            out_q;
   logic [IW-1:0]   ptr;
   logic [N_CH-1:0] sel_oh;
   logic [N_CH-1:0] req;
   logic [N_CH-1:0] gnt;
   logic [IW-1:0]   gnt_idx;
   logic            load_ok;
   logic            xfer;
   logic            fixed_mode;

   assign fixed_mode = (mode_e'(mode) == MODE_FIXED);
   assign load_ok    = !out_valid || out_ready;

   // An out-of-range sel masks every request rather than aliasing onto a real channel.
   assign sel_oh = (int'(sel) < N_CH) ? (N_CH'(1) << sel) : '0;
   assign req    = fixed_mode ? (in_valid & sel_oh) : in_valid;

   rr_arbiter #(.N_CH(N_CH)) u_arb (
      .req     (req),
      .ptr     (ptr),
      .en      (load_ok & rst_n),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign in_ready = gnt;
   assign xfer     = |gnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_q     <= '0;
         ptr       <= '0;
      end else begin
         if (load_ok) begin
            out_valid <= xfer;
         end
         if (xfer) begin
            out_q.ch  <= gnt_idx;
            out_q.dat <= in_data[gnt_idx];
            if (!fixed_mode) begin
               ptr <= (gnt_idx == IW'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
            end
         end
      end
   end

   assign out_data = out_q.dat;
   assign out_ch   = out_q.ch;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: vector table for arbitration/backpressure plus
// hand sequences for forced select, a 3-channel instance and mid-transfer reset.
module tb_stream_mux_rr;

   logic             clk;
   logic             rst_n;
   logic [3:0]       in_valid;
   logic [3:0]       in_ready;
   logic [3:0][3:0]  in_data;
   logic             mode;
   logic [1:0]       sel;
   logic             out_valid;
   logic             out_ready;
   logic [3:0]       out_data;
   logic [1:0]       out_ch;

   logic [2:0]       v3;
   logic [2:0]       ir3;
   logic [2:0][3:0]  d3;
   logic             mode3;
   logic [1:0]       sel3;
   logic             ov3;
   logic             ordy3;
   logic [3:0]       od3;
   logic [1:0]       och3;

   int checks = 0;
   int errors = 0;

   stream_mux_rr #(.N_CH(4), .W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .mode      (mode),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ch    (out_ch)
   );

   stream_mux_rr #(.N_CH(3), .W(4)) dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (v3),
      .in_ready  (ir3),
      .in_data   (d3),
      .mode      (mode3),
      .sel       (sel3),
      .out_valid (ov3),
      .out_ready (ordy3),
      .out_data  (od3),
      .out_ch    (och3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       mode;
      logic [1:0] sel;
      logic [3:0] valid;
      logic       ordy;
      logic [3:0] exp_ir;
      logic       exp_ov;
      logic [1:0] exp_ch;
      logic [3:0] exp_data;
   } vec_t;

   vec_t tbl [25];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial begin
      // Expected outputs in each row are those visible during that row's cycle,
      // i.e. the effect of the previous rows. Data: ch0=A ch1=B ch2=C ch3=D.
      tbl[0]  = '{1'b0, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b0, 2'd0, 4'h0};
      tbl[1]  = '{1'b0, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd0, 4'hA};
      tbl[2]  = '{1'b0, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd1, 4'hB};
      tbl[3]  = '{1'b0, 2'd0, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd2, 4'hC};
      tbl[4]  = '{1'b0, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd3, 4'hD};
      tbl[5]  = '{1'b0, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b1, 2'd0, 4'hA};
      tbl[6]  = '{1'b0, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd0, 4'hA};
      tbl[7]  = '{1'b0, 2'd0, 4'hF, 1'b0, 4'b0010, 1'b0, 2'd0, 4'hA};
      tbl[8]  = '{1'b0, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd1, 4'hB};
      tbl[9]  = '{1'b0, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd1, 4'hB};
      tbl[10] = '{1'b0, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd1, 4'hB};
      tbl[11] = '{1'b0, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd1, 4'hB};
      tbl[12] = '{1'b0, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b1, 2'd2, 4'hC};
      tbl[13] = '{1'b0, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd2, 4'hC};
      tbl[14] = '{1'b0, 2'd0, 4'h8, 1'b1, 4'b1000, 1'b0, 2'd2, 4'hC};
      tbl[15] = '{1'b0, 2'd0, 4'h9, 1'b1, 4'b0001, 1'b1, 2'd3, 4'hD};
      tbl[16] = '{1'b0, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b1, 2'd0, 4'hA};
      tbl[17] = '{1'b0, 2'd0, 4'h9, 1'b1, 4'b1000, 1'b0, 2'd0, 4'hA};
      tbl[18] = '{1'b0, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b1, 2'd3, 4'hD};
      tbl[19] = '{1'b1, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b0, 2'd3, 4'hD};
      tbl[20] = '{1'b1, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hC};
      tbl[21] = '{1'b1, 2'd3, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd2, 4'hC};
      tbl[22] = '{1'b0, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b1, 2'd3, 4'hD};
      tbl[23] = '{1'b0, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b0, 2'd3, 4'hD};
      tbl[24] = '{1'b0, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b1, 2'd0, 4'hA};

      rst_n     = 1'b0;
      in_valid  = 4'hF;
      in_data   = {4'hD, 4'hC, 4'hB, 4'hA};
      mode      = 1'b0;
      sel       = 2'd0;
      out_ready = 1'b1;
      v3        = 3'b111;
      d3        = {4'h5, 4'h2, 4'h1};
      mode3     = 1'b0;
      sel3      = 2'd0;
      ordy3     = 1'b1;

      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      chk("rst_out_ch",    32'(out_ch),    32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      chk("rst_in_ready3", 32'(ir3),       32'd0);
      #11;
      in_valid = 4'h0;
      v3       = 3'b000;
      #10 rst_n = 1'b1;

      for (int i = 0; i < 25; i++) begin
         @(posedge clk); #1;
         mode      = tbl[i].mode;
         sel       = tbl[i].sel;
         in_valid  = tbl[i].valid;
         out_ready = tbl[i].ordy;
         @(negedge clk);
         chk($sformatf("row%0d_in_ready", i),  32'(in_ready),  32'(tbl[i].exp_ir));
         chk($sformatf("row%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
         chk($sformatf("row%0d_out_ch", i),    32'(out_ch),    32'(tbl[i].exp_ch));
         chk($sformatf("row%0d_out_data", i),  32'(out_data),  32'(tbl[i].exp_data));
      end

      // Forced select: data {7,10,3,E}; only ch2 then only ch3 may be taken.
      @(posedge clk); #1;
      in_data  = {4'hE, 4'h3, 4'hA, 4'h7};
      mode     = 1'b1;
      sel      = 2'd2;
      in_valid = 4'hF;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("fix2_out_valid", 32'(out_valid), 32'd1);
         chk("fix2_out_ch",    32'(out_ch),    32'd2);
         chk("fix2_out_data",  32'(out_data),  32'd3);
      end
      @(posedge clk); #1;
      sel = 2'd3;
      @(negedge clk);
      chk("fix3_in_ready", 32'(in_ready), 32'b1000);
      @(posedge clk); #1;
      in_valid = 4'h0;
      @(negedge clk);
      chk("fix3_out_ch",   32'(out_ch),   32'd3);
      chk("fix3_out_data", 32'(out_data), 32'hE);

      // Three-channel instance: sel beyond the last channel grants nothing.
      @(posedge clk); #1;
      mode = 1'b0;
      v3   = 3'b111;
      @(negedge clk);
      chk("n3_rr_in_ready", 32'(ir3), 32'b001);
      @(posedge clk); #1;
      mode3 = 1'b1;
      sel3  = 2'd3;
      @(negedge clk);
      chk("n3_sel3_in_ready", 32'(ir3), 32'b000);
      chk("n3_held_valid",    32'(ov3), 32'd1);
      chk("n3_held_data",     32'(od3), 32'h1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("n3_drain_valid",   32'(ov3), 32'd0);
      chk("n3_drain_ir",      32'(ir3), 32'b000);
      @(posedge clk); #1;
      sel3 = 2'd2;
      @(negedge clk);
      chk("n3_sel2_in_ready", 32'(ir3), 32'b100);
      @(posedge clk); #1;
      v3 = 3'b000;
      @(negedge clk);
      chk("n3_sel2_ch",   32'(och3), 32'd2);
      chk("n3_sel2_data", 32'(od3),  32'h5);

      // Reset while a word is stalled; ptr is 3 beforehand, so a ch3 grant would expose a stale ptr.
      @(posedge clk); #1;
      in_data   = {4'hD, 4'hC, 4'hB, 4'hA};
      mode      = 1'b0;
      in_valid  = 4'b0100;
      out_ready = 1'b0;
      @(negedge clk);
      chk("pre_rst_in_ready", 32'(in_ready), 32'b0100);
      @(posedge clk); #1;
      in_valid = 4'hF;
      @(negedge clk);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out_ch",    32'(out_ch),    32'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_out_data",  32'(out_data),  32'd0);
      chk("arst_out_ch",    32'(out_ch),    32'd0);
      chk("arst_in_ready",  32'(in_ready),  32'd0);
      @(posedge clk); #1;
      in_valid  = 4'b1010;
      out_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'b0010);
      @(posedge clk); #1;
      in_valid = 4'h0;
      @(negedge clk);
      chk("post_rst_out_valid", 32'(out_valid), 32'd1);
      chk("post_rst_out_ch",    32'(out_ch),    32'd1);
      chk("post_rst_out_data",  32'(out_data),  32'hB);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 The block SHALL have parameter N_CH, default 4: number of input channels, legal range 2..16.
REQ-002 The block SHALL have parameter W, default 4: data width per channel, W >= 1.
REQ-003 The block SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, N_CH: per-channel request.
REQ-006 The block SHALL have port in_ready, output, N_CH: per-channel accept.
REQ-007 The block SHALL have port in_data, input, N_CH x W packed, [N_CH-1:0][W-1:0]: channel i data at index i.
REQ-008 The block SHALL have port mode, input, 1: 0 = round-robin, 1 = forced select.
REQ-009 The block SHALL have port sel, input, $clog2(N_CH): channel index used when mode = 1.
REQ-010 The block SHALL have port out_valid, output, 1: output holds data.
REQ-011 The block SHALL have port out_ready, input, 1: downstream accept.
REQ-012 The block SHALL have port out_data, output, W: selected data.
REQ-013 The block SHALL have port out_ch, output, $clog2(N_CH): source channel of out_data.

Function
REQ-014 Input transfer on channel i SHALL occur on a rising edge with in_valid[i] & in_ready[i]; output transfer SHALL occur with out_valid & out_ready.
REQ-015 Output stage SHALL be a single register; load permitted (load_ok) when !out_valid | out_ready.
REQ-016 At most one in_ready bit SHALL be high per cycle: only the granted channel, only when load_ok.
REQ-017 A transferred word SHALL appear on out_data/out_ch with out_valid = 1 on the next cycle (latency 1); back-to-back transfers SHALL sustain 1 word/cycle.
REQ-018 Mode 0 arbitration: grant the lowest channel index at or above ptr (wrapping modulo N_CH) whose in_valid is high.
REQ-019 ptr SHALL update to (granted index + 1) mod N_CH only on an input transfer; otherwise ptr holds.
REQ-020 Mode 1: only channel sel SHALL be grantable; sel >= N_CH SHALL grant nothing; ptr holds.
REQ-021 mode/sel changes SHALL affect only the arbitration in the same cycle and SHALL NOT alter a word already in the output register.
REQ-022 While out_valid & !out_ready, out_data, out_ch and out_valid SHALL hold stable.
REQ-023 Simultaneous output drain and input load SHALL replace the register contents with no bubble.
REQ-024 With no transfer and out_ready high, out_valid SHALL fall next cycle; out_data SHALL hold its last value.
REQ-025 Data bits SHALL pass unmodified, including X/Z; no combinational path from in_data/in_valid to out_valid/out_data.

Reset
REQ-026 On rst_n low, asynchronously: out_valid = 0, out_data = 0, out_ch = 0, ptr = 0; in_ready SHALL be low while rst_n is low.
REQ-027 Reset asserted mid-transfer SHALL discard the held word; first grant after release follows ptr = 0.

Structure
REQ-028 Package stream_mux_pkg SHALL hold the mode enum (MODE_RR = 0, MODE_FIXED = 1) and the default N_CH/W constants.
REQ-029 Arbitration SHALL be in sub-module rr_arbiter (request vector, ptr, enable in; one-hot grant and index out), parameterised by N_CH.

Verification
REQ-030 Mode 0, all four in_valid high, data {a,b,c,d} on ch0..3, out_ready = 1 -> out_ch 0,1,2,3,0 on consecutive cycles, out_data a,b,c,d,a.
REQ-031 Mode 0, out_ready = 0 for 3 cycles after first word -> out_data/out_ch held, in_ready all 0, no word lost once out_ready rises.
REQ-032 Mode 1, sel = 2, all valid, data {7,10,3,x} -> every output word is 3 with out_ch 2; sel = 3 -> out_data x, out_ch 3.
REQ-033 Mode 1, N_CH = 3, sel = 3 -> in_ready = 0 and out_valid falls after drain.
REQ-034 Reset asserted while out_valid = 1 and out_ready = 0 -> out_valid 0 immediately; after release with ch1 and ch3 valid, first grant ch1.
REQ-035 Mode 0, only ch3 valid, then ch0 and ch3 valid -> grant ch3, then ch0 (ptr wrapped to 0).
